// File: rtl/uart_pkg.sv
// Shared UART definitions: frame levels, data width and receiver FSM states.
// Used by both the transmitter and the receiver so the serial protocol stays in one place.
package uart_pkg;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_IDLE_LVL  = 1'b1;
  localparam logic UART_START_LVL = 1'b0;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HI
  } rx_state_t;

endpackage

// File: rtl/rx_sync_2ff.sv
// Two-flop synchronizer for the asynchronous rx pin.
// Resets to the idle line level so a reset never looks like a start bit.
module rx_sync_2ff
  import uart_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= UART_IDLE_LVL;
      sync_q <= UART_IDLE_LVL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling FSM feeding a single valid/ack holding register,
// with sticky framing and overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx_i,
  input  logic                 rx_en_i,
  input  logic                 byte_ack_i,
  input  logic                 err_clr_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 byte_valid_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam logic [BAUD_W-1:0] BAUD_MID  = BAUD_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

  logic rx_s;

  rx_sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx_i),
    .q_o   (rx_s)
  );

  rx_state_t            state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q, busy_d;
  logic                 deliver;
  logic                 ferr_set;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q + 1'b1;
    bit_d    = bit_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    valid_d  = valid_q & ~byte_ack_i;
    ferr_d   = ferr_q & ~err_clr_i;
    ovr_d    = ovr_q & ~err_clr_i;
    deliver  = 1'b0;
    ferr_set = 1'b0;

    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (rx_en_i && rx_s == UART_START_LVL) state_d = START;
      end
      START: begin
        if (baud_q == BAUD_MID) begin
          state_d = (rx_s == UART_START_LVL) ? DATA : IDLE;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
          if (bit_q == BIT_LAST) state_d = STOP;
          else                   bit_d   = bit_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_q == BAUD_LAST) begin
          if (rx_s == UART_IDLE_LVL) begin
            deliver = 1'b1;
            state_d = IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = WAIT_HI;
          end
        end
      end
      WAIT_HI: begin
        baud_d = '0;
        if (rx_s == UART_IDLE_LVL) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Disabling the receiver mid-frame abandons the frame silently.
    if (state_q != IDLE && !rx_en_i) begin
      state_d  = IDLE;
      deliver  = 1'b0;
      ferr_set = 1'b0;
    end

    if (state_d != state_q) baud_d = '0;

    if (deliver) begin
      if (!valid_q || byte_ack_i) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (ferr_set) ferr_d = 1'b1;

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign data_o       = data_q;
  assign byte_valid_o = valid_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = ovr_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: drives 8N1 frames at 5 clocks per bit and checks
// delivered bytes against a scoreboard queue plus flag/handshake behaviour.
module tb_uart_rx;

  localparam int CPB = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_i = 1'b1;
  logic       rx_en_i = 1'b0;
  logic       byte_ack_i = 1'b0;
  logic       err_clr_i = 1'b0;
  logic [7:0] data_o;
  logic       byte_valid_o;
  logic       frame_err_o;
  logic       overrun_o;
  logic       busy_o;

  int         total = 0;
  int         bad = 0;
  int         busy_cnt = 0;
  logic [7:0] exp_q[$];

  uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_i         (rx_i),
    .rx_en_i      (rx_en_i),
    .byte_ack_i   (byte_ack_i),
    .err_clr_i    (err_clr_i),
    .data_o       (data_o),
    .byte_valid_o (byte_valid_o),
    .frame_err_o  (frame_err_o),
    .overrun_o    (overrun_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (busy_o) busy_cnt <= busy_cnt + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives the first nbits of {stop, data, start} LSB-first; optional ack on the stop-sample edge.
  task automatic send_bits(input logic [7:0] d, input logic stop, input int nbits,
                           input bit ack_at_stop);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx_i = fr[i];
      tick(CPB);
    end
    rx_i = 1'b1;
    if (ack_at_stop) begin
      byte_ack_i = 1'b1;
      tick(1);
      byte_ack_i = 1'b0;
    end
  endtask

  task automatic sb_check(input string tag, input bit do_ack);
    int         n;
    logic [7:0] e;
    n = 0;
    while (!byte_valid_o && n < 200) begin
      tick(1);
      n++;
    end
    if (!byte_valid_o) begin
      check({tag, "_timeout"}, 32'(byte_valid_o), 32'd1);
    end else if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(data_o), 32'(e));
      if (do_ack) begin
        byte_ack_i = 1'b1;
        tick(1);
        byte_ack_i = 1'b0;
        check({tag, "_ackclr"}, 32'(byte_valid_o), 32'd0);
      end
    end
  endtask

  initial begin
    int bc;

    // Reset values while reset is held
    tick(3);
    check("rst_data", 32'(data_o), 32'h0);
    check("rst_valid", 32'(byte_valid_o), 32'd0);
    check("rst_ferr", 32'(frame_err_o), 32'd0);
    check("rst_ovr", 32'(overrun_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    reset = 1'b1;
    rx_en_i = 1'b1;
    tick(3);

    // 1: clean frame, held until ack
    exp_q.push_back(8'hA5);
    send_bits(8'hA5, 1'b1, 10, 1'b0);
    tick(10);
    check("t1_hold", 32'(byte_valid_o), 32'd1);
    sb_check("t1_data", 1'b1);
    check("t1_ferr", 32'(frame_err_o), 32'd0);
    check("t1_ovr", 32'(overrun_o), 32'd0);

    // 2: framing error, line low for three bit times after data
    send_bits(8'h3C, 1'b0, 10, 1'b0);
    rx_i = 1'b0;
    tick(2 * CPB);
    check("t2_ferr", 32'(frame_err_o), 32'd1);
    check("t2_valid", 32'(byte_valid_o), 32'd0);
    check("t2_busy_low", 32'(busy_o), 32'd1);
    rx_i = 1'b1;
    tick(5);
    check("t2_idle", 32'(busy_o), 32'd0);
    check("t2_ferr_sticky", 32'(frame_err_o), 32'd1);
    err_clr_i = 1'b1;
    tick(1);
    err_clr_i = 1'b0;
    check("t2_ferr_clr", 32'(frame_err_o), 32'd0);

    // 3: one-clock glitch is rejected in START
    rx_i = 1'b0;
    tick(1);
    rx_i = 1'b1;
    tick(2);
    check("t3_start", 32'(busy_o), 32'd1);
    tick(5);
    check("t3_idle", 32'(busy_o), 32'd0);
    check("t3_valid", 32'(byte_valid_o), 32'd0);
    check("t3_ferr", 32'(frame_err_o), 32'd0);

    // 4a: second byte dropped while holding register full
    exp_q.push_back(8'h11);
    send_bits(8'h11, 1'b1, 10, 1'b0);
    send_bits(8'h22, 1'b1, 10, 1'b0);
    tick(5);
    check("t4a_ovr", 32'(overrun_o), 32'd1);
    sb_check("t4a_data", 1'b1);
    err_clr_i = 1'b1;
    tick(1);
    err_clr_i = 1'b0;
    check("t4a_ovr_clr", 32'(overrun_o), 32'd0);

    // 4b: ack coincides with delivery of the second byte
    exp_q.push_back(8'h11);
    send_bits(8'h11, 1'b1, 10, 1'b0);
    sb_check("t4b_first", 1'b0);
    exp_q.push_back(8'h22);
    send_bits(8'h22, 1'b1, 10, 1'b1);
    check("t4b_valid", 32'(byte_valid_o), 32'd1);
    sb_check("t4b_data", 1'b1);
    check("t4b_ovr", 32'(overrun_o), 32'd0);

    // 5: reset during data bit 3, then resend
    send_bits(8'h5A, 1'b1, 4, 1'b0);
    rx_i = 1'b1;
    tick(2);
    check("t5_busy_pre", 32'(busy_o), 32'd1);
    reset = 1'b0;
    #1;
    check("t5_data", 32'(data_o), 32'h0);
    check("t5_valid", 32'(byte_valid_o), 32'd0);
    check("t5_ferr", 32'(frame_err_o), 32'd0);
    check("t5_ovr", 32'(overrun_o), 32'd0);
    check("t5_busy", 32'(busy_o), 32'd0);
    tick(2);
    reset = 1'b1;
    tick(2);
    exp_q.push_back(8'h5A);
    send_bits(8'h5A, 1'b1, 10, 1'b0);
    sb_check("t5_resend", 1'b1);

    // 6: disable mid-DATA, then frame sent while disabled is ignored
    send_bits(8'h96, 1'b1, 3, 1'b0);
    rx_i = 1'b0;
    check("t6_busy_pre", 32'(busy_o), 32'd1);
    rx_en_i = 1'b0;
    tick(1);
    check("t6_abort", 32'(busy_o), 32'd0);
    rx_i = 1'b1;
    tick(8 * CPB);
    bc = busy_cnt;
    send_bits(8'h77, 1'b1, 10, 1'b0);
    tick(5);
    check("t6_busy_off", 32'(busy_cnt), 32'(bc));
    check("t6_valid", 32'(byte_valid_o), 32'd0);
    rx_en_i = 1'b1;
    tick(2);
    exp_q.push_back(8'hC3);
    send_bits(8'hC3, 1'b1, 10, 1'b0);
    sb_check("t6_recover", 1'b1);
    check("t6_ferr", 32'(frame_err_o), 32'd0);
    check("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
